// File: rtl/axi_pkg.sv
// Shared AXI4 encodings and the read-burst generator state type.
package axi_pkg;

  localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
  localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;
  localparam int unsigned AXI_4KB        = 4096;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } rd_state_e;

endpackage

// File: rtl/sync_fifo_len.sv
// Small synchronous FIFO holding the length of each in-flight burst.
module sync_fifo_len #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count, count_nxt;
  logic             do_push, do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A push into a full FIFO is accepted when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (do_push && !do_pop)      count_nxt = count + 1'b1;
    else if (!do_push && do_pop) count_nxt = count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count_nxt;
      full  <= (count_nxt == (AW+1)'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/axi_rd_burst_gen.sv
// AXI4 read master: splits one command into INCR bursts (4 KB safe, bounded
// outstanding) and forwards R data straight to a valid/ready stream.
module axi_rd_burst_gen
  import axi_pkg::*;
#(
  parameter int unsigned AXI_ADDR_WIDTH  = 42,
  parameter int unsigned AXI_DATA_WIDTH  = 256,
  parameter int unsigned AXI_ID_WIDTH    = 1,
  parameter int unsigned AXI_BURST_WIDTH = 8,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned CNT_W           = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [AXI_ADDR_WIDTH-1:0]  cmd_addr,
  input  logic [CNT_W-1:0]           cmd_beats,
  input  logic [AXI_BURST_WIDTH-1:0] cmd_max_len,
  output logic [AXI_ADDR_WIDTH-1:0]  m_axi_araddr,
  output logic [AXI_BURST_WIDTH-1:0] m_axi_arlen,
  output logic [2:0]                 m_axi_arsize,
  output logic [1:0]                 m_axi_arburst,
  output logic [AXI_ID_WIDTH-1:0]    m_axi_arid,
  output logic                       m_axi_arvalid,
  input  logic                       m_axi_arready,
  input  logic [AXI_DATA_WIDTH-1:0]  m_axi_rdata,
  input  logic [AXI_ID_WIDTH-1:0]    m_axi_rid,
  input  logic [1:0]                 m_axi_rresp,
  input  logic                       m_axi_rlast,
  input  logic                       m_axi_rvalid,
  output logic                       m_axi_rready,
  output logic [AXI_DATA_WIDTH-1:0]  m_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic                       busy,
  output logic                       done,
  output logic                       err_rlast,
  output logic                       err_resp,
  output logic                       err_align
);

  localparam int unsigned BPB  = AXI_DATA_WIDTH / 8;
  localparam int unsigned SIZE = $clog2(BPB);
  localparam int unsigned LW   = ((CNT_W > 13) ? CNT_W : 13) + 1;
  localparam int unsigned BW   = AXI_BURST_WIDTH + 1;
  localparam int unsigned OW   = $clog2(MAX_OUTSTANDING) + 1;

  rd_state_e                  state, state_nxt;
  logic [AXI_ADDR_WIDTH-1:0]  addr_q, cmd_addr_al, src_addr;
  logic [CNT_W-1:0]           ar_rem, r_rem, src_rem;
  logic [AXI_BURST_WIDTH-1:0] max_len_q, src_max;
  logic [OW-1:0]              inflight;
  logic [BW-1:0]              beat_cnt, len, fifo_head;
  logic [LW-1:0]              bound, len_w;
  logic cmd_hs, cmd_misalign, ar_slot_free, ar_load;
  logic r_active, r_hs, exp_last, burst_done, fifo_full, fifo_empty;

  assign cmd_ready    = (state == ST_IDLE) && !reset;
  assign busy         = (state != ST_IDLE);
  assign done         = (state == ST_DONE);
  assign cmd_hs       = cmd_valid && cmd_ready;
  assign cmd_addr_al  = cmd_addr & ~AXI_ADDR_WIDTH'(BPB - 1);
  assign cmd_misalign = |(cmd_addr & AXI_ADDR_WIDTH'(BPB - 1));

  assign m_axi_arsize  = 3'(SIZE);
  assign m_axi_arburst = AXI_BURST_INCR;
  assign m_axi_arid    = '0;

  assign r_active     = (state == ST_ISSUE) || (state == ST_DRAIN);
  assign m_axi_rready = r_active && m_ready;
  assign m_valid      = r_active && m_axi_rvalid;
  assign m_data       = m_axi_rdata;
  assign r_hs         = m_axi_rvalid && m_axi_rready;
  assign exp_last     = !fifo_empty && ((beat_cnt + 1'b1) == fifo_head);
  assign burst_done   = r_hs && exp_last;

  // The first burst is sized straight from the command so arvalid can rise
  // the cycle after the command handshake; later bursts use the latched copy.
  always_comb begin
    src_addr = (state == ST_IDLE) ? cmd_addr_al : addr_q;
    src_rem  = (state == ST_IDLE) ? cmd_beats   : ar_rem;
    src_max  = (state == ST_IDLE) ? cmd_max_len : max_len_q;
    bound    = (LW'(AXI_4KB) - LW'(src_addr[11:0])) >> SIZE;
    len_w    = LW'(src_rem);
    if ((LW'(src_max) + LW'(1)) < len_w) len_w = LW'(src_max) + LW'(1);
    if (bound < len_w) len_w = bound;
    len = BW'(len_w);
  end

  assign ar_slot_free = !m_axi_arvalid || m_axi_arready;

  always_comb begin
    ar_load = 1'b0;
    if (state == ST_IDLE)
      ar_load = cmd_hs && (cmd_beats != '0);
    else if (state == ST_ISSUE)
      ar_load = (ar_rem != '0) && ar_slot_free && !fifo_full &&
                (inflight < OW'(MAX_OUTSTANDING));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (cmd_hs) state_nxt = (cmd_beats == '0) ? ST_DONE : ST_ISSUE;
      ST_ISSUE: if ((ar_rem == '0) && ar_slot_free) state_nxt = ST_DRAIN;
      ST_DRAIN: if ((r_rem == '0) || (r_hs && (r_rem == CNT_W'(1)))) state_nxt = ST_DONE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      m_axi_arvalid <= 1'b0;
      m_axi_araddr  <= '0;
      m_axi_arlen   <= '0;
      addr_q        <= '0;
      ar_rem        <= '0;
      r_rem         <= '0;
      max_len_q     <= '0;
      inflight      <= '0;
      beat_cnt      <= '0;
      err_rlast     <= 1'b0;
      err_resp      <= 1'b0;
      err_align     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (cmd_hs) begin
        addr_q    <= cmd_addr_al;
        ar_rem    <= cmd_beats;
        r_rem     <= cmd_beats;
        max_len_q <= cmd_max_len;
        err_align <= cmd_misalign;
        err_rlast <= 1'b0;
        err_resp  <= 1'b0;
      end
      // addr_q/ar_rem track the next burst still to be presented on AR.
      if (ar_load) begin
        m_axi_arvalid <= 1'b1;
        m_axi_araddr  <= src_addr;
        m_axi_arlen   <= AXI_BURST_WIDTH'(len - 1'b1);
        addr_q        <= src_addr + (AXI_ADDR_WIDTH'(len) << SIZE);
        ar_rem        <= src_rem - CNT_W'(len);
      end else if (m_axi_arvalid && m_axi_arready) begin
        m_axi_arvalid <= 1'b0;
      end
      case ({ar_load, burst_done})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
      if (r_hs) begin
        if (r_rem != '0) r_rem <= r_rem - 1'b1;
        beat_cnt <= burst_done ? '0 : beat_cnt + 1'b1;
        if (m_axi_rlast != exp_last) err_rlast <= 1'b1;
        // A beat tagged with an ID this master never issues is reported as a response error.
        if ((m_axi_rresp != AXI_RESP_OKAY) || (m_axi_rid != '0)) err_resp <= 1'b1;
      end
    end
  end

  sync_fifo_len #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (BW)
  ) u_len_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (ar_load),
    .push_data (len),
    .pop       (burst_done),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_axi_rd_burst_gen.sv
// Directed bench for axi_rd_burst_gen with a small in-order AXI read slave.
module tb_axi_rd_burst_gen;

  logic         clk = 1'b0;
  logic         reset;
  logic         cmd_valid, cmd_ready;
  logic [41:0]  cmd_addr;
  logic [15:0]  cmd_beats;
  logic [7:0]   cmd_max_len;
  logic [41:0]  m_axi_araddr;
  logic [7:0]   m_axi_arlen;
  logic [2:0]   m_axi_arsize;
  logic [1:0]   m_axi_arburst;
  logic [0:0]   m_axi_arid;
  logic         m_axi_arvalid, m_axi_arready;
  logic [255:0] m_axi_rdata;
  logic [0:0]   m_axi_rid;
  logic [1:0]   m_axi_rresp;
  logic         m_axi_rlast, m_axi_rvalid, m_axi_rready;
  logic [255:0] m_data;
  logic         m_valid, m_ready;
  logic         busy, done, err_rlast, err_resp, err_align;

  always #5 clk = ~clk;

  axi_rd_burst_gen #(
    .AXI_ADDR_WIDTH  (42),
    .AXI_DATA_WIDTH  (256),
    .AXI_ID_WIDTH    (1),
    .AXI_BURST_WIDTH (8),
    .MAX_OUTSTANDING (4),
    .CNT_W           (16)
  ) dut (
    .clk (clk), .reset (reset),
    .cmd_valid (cmd_valid), .cmd_ready (cmd_ready), .cmd_addr (cmd_addr),
    .cmd_beats (cmd_beats), .cmd_max_len (cmd_max_len),
    .m_axi_araddr (m_axi_araddr), .m_axi_arlen (m_axi_arlen),
    .m_axi_arsize (m_axi_arsize), .m_axi_arburst (m_axi_arburst),
    .m_axi_arid (m_axi_arid), .m_axi_arvalid (m_axi_arvalid),
    .m_axi_arready (m_axi_arready),
    .m_axi_rdata (m_axi_rdata), .m_axi_rid (m_axi_rid), .m_axi_rresp (m_axi_rresp),
    .m_axi_rlast (m_axi_rlast), .m_axi_rvalid (m_axi_rvalid),
    .m_axi_rready (m_axi_rready),
    .m_data (m_data), .m_valid (m_valid), .m_ready (m_ready),
    .busy (busy), .done (done),
    .err_rlast (err_rlast), .err_resp (err_resp), .err_align (err_align)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // slave control and state
  bit ar_en = 1'b1, r_en = 1'b1, mr_toggle = 1'b0;
  int pend_q[$];
  int cur_beat = 0, gidx = 0, bad_last = -1, bad_resp = -1;

  // monitor records
  logic [41:0]  mon_ar_addr[$];
  int           mon_ar_len[$];
  int           beats_at_ar[$];
  logic [255:0] beats[$];
  int           last_beat_cyc = 0, mirror_err = 0, hs_cyc = 0;

  function automatic logic [255:0] pat(input int i);
    return {8{32'hA500_0000 | 32'(i)}};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // AXI read slave: samples handshakes on the falling edge, drives after the rising edge.
  initial begin
    bit ar_hs, r_hs;
    forever begin
      @(negedge clk);
      ar_hs = m_axi_arvalid && m_axi_arready;
      r_hs  = m_axi_rvalid && m_axi_rready;
      if (ar_hs) pend_q.push_back(int'(m_axi_arlen) + 1);
      if (r_hs && pend_q.size() > 0) begin
        cur_beat++;
        gidx++;
        if (cur_beat == pend_q[0]) begin
          void'(pend_q.pop_front());
          cur_beat = 0;
        end
      end
      @(posedge clk);
      #1;
      m_axi_arready = ar_en;
      m_ready = mr_toggle ? ~m_ready : 1'b1;
      if (r_en && pend_q.size() > 0) begin
        m_axi_rvalid = 1'b1;
        m_axi_rdata  = pat(gidx);
        m_axi_rlast  = (cur_beat == pend_q[0] - 1) != (gidx == bad_last);
        m_axi_rresp  = (gidx == bad_resp) ? 2'd2 : 2'd0;
      end else begin
        m_axi_rvalid = 1'b0;
        m_axi_rlast  = 1'b0;
        m_axi_rresp  = 2'd0;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (m_axi_arvalid && m_axi_arready) begin
      mon_ar_addr.push_back(m_axi_araddr);
      mon_ar_len.push_back(int'(m_axi_arlen) + 1);
      beats_at_ar.push_back(beats.size());
      if (m_axi_arsize !== 3'd5 || m_axi_arburst !== 2'd1 || m_axi_arid !== 1'b0) mirror_err++;
    end
    if (m_valid && m_ready) begin
      beats.push_back(m_data);
      last_beat_cyc = cyc;
    end
    if (busy && !done && ((m_axi_rready !== m_ready) || (m_valid !== m_axi_rvalid))) mirror_err++;
  end

  task automatic clear_state();
    pend_q.delete();
    cur_beat = 0;
    gidx = 0;
    mon_ar_addr.delete();
    mon_ar_len.delete();
    beats_at_ar.delete();
    beats.delete();
    mirror_err = 0;
  endtask

  task automatic send_cmd(input logic [41:0] a, input logic [15:0] b, input logic [7:0] ml,
                          input int bl, input int br);
    int n = 0;
    @(posedge clk);
    #3;
    clear_state();
    bad_last = bl;
    bad_resp = br;
    cmd_addr = a;
    cmd_beats = b;
    cmd_max_len = ml;
    cmd_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!cmd_ready && n < 50);
    check("cmd_accept", cmd_ready, 1);
    hs_cyc = cyc;
    @(posedge clk);
    #3;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int dcyc);
    int n = 0;
    dcyc = -1;
    while (n < limit) begin
      @(negedge clk);
      n++;
      if (done) begin
        dcyc = cyc;
        break;
      end
    end
    check("done_seen", dcyc >= 0, 1);
    check("cmd_ready_in_done", cmd_ready, 0);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("cmd_ready_after_done", cmd_ready, 1);
  endtask

  task automatic check_beats(input string tag, input int n);
    int bad = 0;
    check(tag, beats.size(), n);
    foreach (beats[i]) if (beats[i] !== pat(i)) bad++;
    check("beat_data_order", bad, 0);
    check("mirror_and_ar_fields", mirror_err, 0);
  endtask

  initial begin
    int d;
    reset = 1'b1;
    cmd_valid = 1'b0; cmd_addr = '0; cmd_beats = '0; cmd_max_len = '0;
    m_axi_arready = 1'b1; m_axi_rdata = '0; m_axi_rid = '0; m_axi_rresp = '0;
    m_axi_rlast = 1'b0; m_axi_rvalid = 1'b0; m_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 0);
    @(posedge clk);
    #3 reset = 1'b0;
    @(negedge clk);
    check("rst_arvalid", m_axi_arvalid, 0);
    check("rst_araddr", m_axi_araddr, 0);
    check("rst_arlen", m_axi_arlen, 0);
    check("rst_arsize", m_axi_arsize, 5);
    check("rst_arburst", m_axi_arburst, 1);
    check("rst_arid", m_axi_arid, 0);
    check("rst_rready_mvalid", {m_axi_rready, m_valid}, 0);
    check("rst_busy_done", {busy, done}, 0);
    check("rst_err", {err_rlast, err_resp, err_align}, 0);
    check("idle_cmd_ready", cmd_ready, 1);

    // single burst
    send_cmd(42'h1000, 16'd5, 8'd15, -1, -1);
    @(negedge clk);
    check("t1_arvalid_next_cycle", m_axi_arvalid, 1);
    check("t1_araddr", m_axi_araddr, 42'h1000);
    check("t1_arlen", m_axi_arlen, 4);
    wait_done(100, d);
    check("t1_ar_count", mon_ar_addr.size(), 1);
    check_beats("t1_beats", 5);
    check("t1_done_latency", d - last_beat_cyc, 1);
    check("t1_err", {err_rlast, err_resp, err_align}, 0);

    // 4 KB split
    send_cmd(42'h1F80, 16'd16, 8'd15, -1, -1);
    wait_done(200, d);
    check("t2_ar_count", mon_ar_addr.size(), 2);
    check("t2_ar0_addr", mon_ar_addr[0], 42'h1F80);
    check("t2_ar0_len", mon_ar_len[0], 4);
    check("t2_ar1_addr", mon_ar_addr[1], 42'h2000);
    check("t2_ar1_len", mon_ar_len[1], 12);
    check_beats("t2_beats", 16);

    // outstanding limit
    r_en = 1'b0;
    send_cmd(42'h0, 16'd40, 8'd7, -1, -1);
    repeat (12) @(negedge clk);
    check("t3_ar_held_count", mon_ar_addr.size(), 4);
    check("t3_arvalid_low", m_axi_arvalid, 0);
    check("t3_ar3_addr", mon_ar_addr[3], 42'h300);
    r_en = 1'b1;
    wait_done(400, d);
    check("t3_ar_count", mon_ar_addr.size(), 5);
    check("t3_ar4_addr", mon_ar_addr[4], 42'h400);
    check("t3_ar4_after_burst", (beats_at_ar.size() == 5) ? (beats_at_ar[4] >= 8) : 1'b0, 1);
    check_beats("t3_beats", 40);

    // errors
    send_cmd(42'h1000, 16'd5, 8'd15, 2, -1);
    wait_done(100, d);
    check("t4_err_rlast", err_rlast, 1);
    check("t4_err_resp_clear", {err_resp, err_align}, 0);
    check_beats("t4_beats", 5);
    send_cmd(42'h1004, 16'd3, 8'd15, -1, 1);
    @(negedge clk);
    check("t4_rlast_cleared", err_rlast, 0);
    check("t4_align_set", err_align, 1);
    wait_done(100, d);
    check("t4_err_resp", err_resp, 1);
    check("t4_align_addr", mon_ar_addr[0], 42'h1000);
    check("t4_align_len", mon_ar_len[0], 3);
    send_cmd(42'h2000, 16'd2, 8'd15, -1, -1);
    wait_done(100, d);
    check("t4_all_clear", {err_rlast, err_resp, err_align}, 0);

    // backpressure
    mr_toggle = 1'b1;
    send_cmd(42'h0, 16'd20, 8'd3, -1, -1);
    wait_done(400, d);
    mr_toggle = 1'b0;
    check("t5_ar_count", mon_ar_addr.size(), 5);
    check_beats("t5_beats", 20);

    // reset mid-drain
    r_en = 1'b0;
    send_cmd(42'h0, 16'd8, 8'd7, -1, -1);
    repeat (4) @(negedge clk);
    check("t6_busy_before", busy, 1);
    check("t6_arvalid_before", m_axi_arvalid, 0);
    @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("t6_rst_arvalid", m_axi_arvalid, 0);
    check("t6_rst_rready", m_axi_rready, 0);
    check("t6_rst_busy", busy, 0);
    @(posedge clk);
    #3 reset = 1'b0;
    clear_state();
    r_en = 1'b1;
    @(negedge clk);
    check("t6_cmd_ready_after", cmd_ready, 1);

    // zero length
    send_cmd(42'h3000, 16'd0, 8'd15, -1, -1);
    wait_done(10, d);
    check("t7_done_within_2", (d - hs_cyc >= 1) && (d - hs_cyc <= 2), 1);
    check("t7_no_ar", mon_ar_addr.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
